exibe_sequencia: RTL

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

---
 rtl/exibe_sequencia.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays back a stored LED sequence, one position at a time.
// Each position is loaded from an external memory (CARREGA), shown for
// T_ACESO cycles (MOSTRA) and followed by T_APAGADO dark cycles (INTERVALO).
// It then either advances the address (PROXIMO) or finishes with a one-cycle
// pronto pulse (FIM).
//
// Ports:
//   clock     - system clock, rising-edge active
//   reset     - synchronous, active-high reset
//   iniciar   - start request, honoured only while idle (INICIAL)
//   abortar   - synchronous abort of a running playback
//   limite    - index of the last position to show (N = limite+1)
//   dado_mem  - one-hot pattern read combinationally at endereco
//   endereco  - sequence memory address
//   leds      - registered LED drive
//   ocupado   - high whenever not idle
//   pronto    - one-cycle pulse when playback completes
//   db_estado - current FSM state code, for debug display
module exibe_sequencia #(
  parameter int unsigned T_ACESO   = 500,
  parameter int unsigned T_APAGADO = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL   = 3'b000,
    CARREGA   = 3'b001,
    MOSTRA    = 3'b010,
    INTERVALO = 3'b011,
    PROXIMO   = 3'b100,
    FIM       = 3'b101
  } estado_t;

  localparam logic [9:0] FIM_ACESO   = 10'(T_ACESO - 1);
  localparam logic [9:0] FIM_APAGADO = 10'(T_APAGADO - 1);

  estado_t    estado;
  estado_t    estado_prox;
  logic [9:0] timer;
  logic [3:0] lim_reg;
  logic       fim_aceso;
  logic       fim_apagado;
  logic       ultimo;

  always_comb begin
    fim_aceso   = (timer == FIM_ACESO);
    fim_apagado = (timer == FIM_APAGADO);
    ultimo      = (endereco == lim_reg);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state logic; abortar overrides every running state
  always_comb begin
    estado_prox = INICIAL;
    if (estado != INICIAL && abortar) begin
      estado_prox = INICIAL;
    end else begin
      case (estado)
        INICIAL:   estado_prox = (iniciar && !abortar) ? CARREGA : INICIAL;
        CARREGA:   estado_prox = MOSTRA;
        MOSTRA:    estado_prox = fim_aceso ? INTERVALO : MOSTRA;
        INTERVALO: begin
          if (fim_apagado) begin
            estado_prox = ultimo ? FIM : PROXIMO;
          end else begin
            estado_prox = INTERVALO;
          end
        end
        PROXIMO:   estado_prox = CARREGA;
        FIM:       estado_prox = INICIAL;
        default:   estado_prox = INICIAL;
      endcase
    end
  end

  // Datapath registers: address, LED drive, timer and latched limit
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco <= '0;
      leds     <= '0;
      timer    <= '0;
      lim_reg  <= '0;
    end else if (estado != INICIAL && abortar) begin
      endereco <= '0;
      leds     <= '0;
      timer    <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          endereco <= '0;
          leds     <= '0;
          timer    <= '0;
          if (iniciar && !abortar) begin
            lim_reg <= limite;
          end
        end
        CARREGA: begin
          leds  <= dado_mem;
          timer <= '0;
        end
        MOSTRA: begin
          if (fim_aceso) begin
            leds  <= '0;
            timer <= '0;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        INTERVALO: begin
          if (fim_apagado) begin
            timer <= '0;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        PROXIMO: begin
          endereco <= endereco + 4'd1;
          timer    <= '0;
        end
        FIM: begin
          endereco <= '0;
          leds     <= '0;
          timer    <= '0;
        end
        default: begin
          endereco <= '0;
          leds     <= '0;
          timer    <= '0;
        end
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    ocupado   = (estado != INICIAL);
    pronto    = (estado == FIM);
    db_estado = estado;
  end

endmodule
